// File: rtl/icache_refill_if.sv
// icache_refill_if: memory-bus handshake between the line-fill engine and the interconnect.
//   mem_req_valid/mem_req_addr/mem_req_ready : one burst request per fill
//   mem_rsp_valid/mem_rsp_data/mem_rsp_err   : response beats, no backpressure
// Modports: master = refill engine, slave = memory side.
interface icache_refill_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mem_req_valid;
    logic [31:0]      mem_req_addr;
    logic             mem_req_ready;
    logic             mem_rsp_valid;
    logic [WIDTH-1:0] mem_rsp_data;
    logic             mem_rsp_err;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  mem_rsp_err
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        output mem_rsp_err
    );
endinterface

// File: rtl/icache_refill.sv
// icache_refill: instruction-cache line-fill engine.
// Accepts a miss, issues one burst on the memory bus, writes each beat into the 512-word
// data RAM, then writes the tag/valid entry and pulses fill_done.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   miss_valid/miss_addr       miss request, accepted when miss_ready is high
//   miss_ready                 engine idle (decoded from state)
//   mem                        memory bus (icache_refill_if.master)
//   wr_addr/wr_data/wr_en      data RAM write port, address {index, word offset}
//   tag_wr_*                   tag RAM write port
//   crit_valid/crit_data       missing word, for early restart
//   fill_done/fill_err         completion pulse and its failure qualifier
// Build option: define ICACHE_REFILL_CWF_EN for critical-word-first requests; otherwise the
// burst starts at the line base and beats arrive in order.
module icache_refill #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_valid,
    input  logic [31:0]                        miss_addr,
    output logic                               miss_ready,
    icache_refill_if.master                    mem,
    output logic [8:0]                         wr_addr,
    output logic [WIDTH-1:0]                   wr_data,
    output logic                               wr_en,
    output logic                               tag_wr_en,
    output logic [8-$clog2(LINE_WORDS):0]      tag_wr_index,
    output logic [20:0]                        tag_wr_tag,
    output logic                               tag_wr_valid,
    output logic                               crit_valid,
    output logic [WIDTH-1:0]                   crit_data,
    output logic                               fill_done,
    output logic                               fill_err
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {StIdle, StReq, StFill, StCommit} state_e;

    state_e           state;
    logic [29:0]      word_addr_q;  // miss_addr[31:2]
    logic [OFF_W-1:0] beat_cnt_q;
    logic             err_q;

    logic [OFF_W-1:0] miss_off;
    logic [OFF_W-1:0] start_off;
    logic [OFF_W-1:0] beat_off;
    logic [31:0]      req_mask;
    logic             beat_ok;
    logic             beat_last;

    assign miss_off = word_addr_q[OFF_W-1:0];

`ifdef ICACHE_REFILL_CWF_EN
    // Memory wraps within the line starting at the missing word.
    assign start_off = miss_off;
    assign req_mask  = 32'h3;
`else
    assign start_off = '0;
    assign req_mask  = LINE_MASK;
`endif

    // Offset arithmetic wraps naturally in OFF_W bits.
    assign beat_off   = start_off + beat_cnt_q;
    assign beat_ok    = !err_q && !mem.mem_rsp_err;
    assign beat_last  = (beat_cnt_q == OFF_W'(LINE_WORDS - 1));
    assign miss_ready = (state == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= StIdle;
            word_addr_q       <= '0;
            beat_cnt_q        <= '0;
            err_q             <= 1'b0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_req_addr  <= '0;
            wr_addr           <= '0;
            wr_data           <= '0;
            wr_en             <= 1'b0;
            tag_wr_en         <= 1'b0;
            tag_wr_index      <= '0;
            tag_wr_tag        <= '0;
            tag_wr_valid      <= 1'b0;
            crit_valid        <= 1'b0;
            crit_data         <= '0;
            fill_done         <= 1'b0;
            fill_err          <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            crit_valid <= 1'b0;
            tag_wr_en  <= 1'b0;
            fill_done  <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (miss_valid) begin
                        word_addr_q       <= miss_addr[31:2];
                        beat_cnt_q        <= '0;
                        err_q             <= 1'b0;
                        mem.mem_req_valid <= 1'b1;
                        mem.mem_req_addr  <= miss_addr & ~req_mask;
                        state             <= StReq;
                    end
                end
                StReq: begin
                    if (mem.mem_req_ready) begin
                        mem.mem_req_valid <= 1'b0;
                        state             <= StFill;
                    end
                end
                StFill: begin
                    if (mem.mem_rsp_valid) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        wr_addr    <= {word_addr_q[8:OFF_W], beat_off};
                        wr_data    <= mem.mem_rsp_data;
                        wr_en      <= beat_ok;
                        if (beat_ok && (beat_off == miss_off)) begin
                            crit_valid <= 1'b1;
                            crit_data  <= mem.mem_rsp_data;
                        end
                        if (mem.mem_rsp_err) begin
                            err_q <= 1'b1;
                        end
                        // Tag write lands in the same cycle as the last data write.
                        if (beat_last) begin
                            tag_wr_en    <= 1'b1;
                            tag_wr_index <= word_addr_q[8:OFF_W];
                            tag_wr_tag   <= word_addr_q[29:9];
                            tag_wr_valid <= beat_ok;
                            fill_done    <= 1'b1;
                            fill_err     <= !beat_ok;
                            state        <= StCommit;
                        end
                    end
                end
                StCommit: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill.sv
`timescale 1ns/1ps
module tb_icache_refill;
    localparam int unsigned WIDTH      = 32;
    localparam int unsigned LINE_WORDS = 4;
`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             miss_valid;
    logic [31:0]      miss_addr;
    logic             miss_ready;
    logic [8:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic             tag_wr_en;
    logic [6:0]       tag_wr_index;
    logic [20:0]      tag_wr_tag;
    logic             tag_wr_valid;
    logic             crit_valid;
    logic [WIDTH-1:0] crit_data;
    logic             fill_done;
    logic             fill_err;

    icache_refill_if #(.WIDTH(WIDTH)) bus ();

    icache_refill #(.WIDTH(WIDTH), .LINE_WORDS(LINE_WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .mem          (bus),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .tag_wr_en    (tag_wr_en),
        .tag_wr_index (tag_wr_index),
        .tag_wr_tag   (tag_wr_tag),
        .tag_wr_valid (tag_wr_valid),
        .crit_valid   (crit_valid),
        .crit_data    (crit_data),
        .fill_done    (fill_done),
        .fill_err     (fill_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Event counters and last-seen values, sampled away from the active edge.
    int          done_cnt = 0;
    int          wr_cnt   = 0;
    int          crit_cnt = 0;
    int          tag_cnt  = 0;
    logic [31:0] last_crit_data;
    logic [6:0]  last_tag_idx;
    logic [20:0] last_tag;
    logic        last_tag_valid;
    logic        last_fill_err;

    always @(negedge clk) begin
        if (fill_done) done_cnt++;
        if (wr_en) wr_cnt++;
        if (crit_valid) begin
            crit_cnt++;
            last_crit_data = crit_data;
        end
        if (tag_wr_en) begin
            tag_cnt++;
            last_tag_idx   = tag_wr_index;
            last_tag       = tag_wr_tag;
            last_tag_valid = tag_wr_valid;
            last_fill_err  = fill_err;
        end
    end

    // Reference model of the current fill.
    logic [1:0]  m_off;
    int          m_start;
    logic [6:0]  m_idx;
    logic [20:0] m_tag;
    logic        m_err;
    logic [31:0] exp_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_model(input logic [31:0] addr);
        m_off   = addr[3:2];
        m_idx   = addr[10:4];
        m_tag   = addr[31:11];
        m_err   = 1'b0;
        m_start = CWF ? int'(m_off) : 0;
        exp_req = CWF ? (addr & ~32'h3) : (addr & ~32'hF);
    endtask

    task automatic check_reset_outputs();
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_req_addr", bus.mem_req_addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_tag_wr_en", tag_wr_en, 0);
        chk("rst_tag_valid", tag_wr_valid, 0);
        chk("rst_crit_valid", crit_valid, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_fill_err", fill_err, 0);
    endtask

    task automatic accept_miss(input logic [31:0] addr, input bit hold);
        miss_addr  = addr;
        miss_valid = 1'b1;
        chk("accept_ready", miss_ready, 1);
        tick();
        if (!hold) miss_valid = 1'b0;
        set_model(addr);
        chk("req_valid", bus.mem_req_valid, 1);
        chk("req_addr", bus.mem_req_addr, exp_req);
        chk("busy", miss_ready, 0);
    endtask

    task automatic grant(input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            bus.mem_req_ready = 1'b0;
            tick();
            chk("req_hold_valid", bus.mem_req_valid, 1);
            chk("req_hold_addr", bus.mem_req_addr, exp_req);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("req_drop", bus.mem_req_valid, 0);
    endtask

    // Drives beat k after gap idle cycles; checks the write one cycle later.
    task automatic beat(input int k, input logic err, input int gap);
        logic [1:0]  off;
        logic        ok;
        logic [31:0] d;
        for (int g = 0; g < gap; g++) begin
            tick();
            chk("gap_no_wr", wr_en, 0);
        end
        d = 32'hA0 + 32'(k);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = d;
        bus.mem_rsp_err   = err;
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_err   = 1'b0;
        off = 2'(m_start + k);
        ok  = !m_err && !err;
        chk("wr_en", wr_en, ok);
        if (ok) begin
            chk("wr_addr", wr_addr, {m_idx, off});
            chk("wr_data", wr_data, d);
        end
        chk("crit_valid", crit_valid, ok && (off == m_off));
        if (ok && (off == m_off)) chk("crit_data", crit_data, d);
        m_err = m_err | err;
        chk("tag_wr_en", tag_wr_en, k == 3);
        chk("fill_done", fill_done, k == 3);
        if (k == 3) begin
            chk("tag_index", tag_wr_index, m_idx);
            chk("tag_tag", tag_wr_tag, m_tag);
            chk("tag_valid", tag_wr_valid, !m_err);
            chk("fill_err", fill_err, m_err);
            chk("commit_busy", miss_ready, 0);
        end
    endtask

    task automatic commit_check();
        tick();
        chk("post_ready", miss_ready, 1);
        chk("post_tag_wr_en", tag_wr_en, 0);
        chk("post_fill_done", fill_done, 0);
    endtask

    task automatic do_fill(input logic [31:0] addr, input int req_wait, input int gap,
                           input int err_beat);
        accept_miss(addr, 1'b0);
        grant(req_wait);
        for (int k = 0; k < 4; k++) begin
            beat(k, k == err_beat, (k == 0) ? 0 : gap);
        end
        commit_check();
    endtask

    typedef struct {
        logic [31:0] addr;
        int          req_wait;
        int          gap;
        int          err_beat;
        int          exp_writes;
        int          exp_crit;
        logic [31:0] exp_crit_data;
        logic [6:0]  exp_idx;
        logic [20:0] exp_tag;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, c0, t0;

        vecs[0] = '{32'h0000_1234, 0, 0, 9, 4, 1, CWF ? 32'hA0 : 32'hA1, 7'h23, 21'h2, 1'b1};
        vecs[1] = '{32'h0000_1234, 0, 0, 1, 1, CWF ? 1 : 0, 32'hA0, 7'h23, 21'h2, 1'b0};
        vecs[2] = '{32'h0000_1234, 5, 2, 9, 4, 1, CWF ? 32'hA0 : 32'hA1, 7'h23, 21'h2, 1'b1};
        vecs[3] = '{32'hFFFF_F7FC, 0, 1, 9, 4, 1, CWF ? 32'hA0 : 32'hA3, 7'h7F, 21'h1FFFFE,
                    1'b1};
        vecs[4] = '{32'h0000_0000, 0, 0, 0, 0, 0, 32'h0, 7'h00, 21'h0, 1'b0};
        vecs[5] = '{32'h0000_0008, 0, 0, 3, 3, 1, CWF ? 32'hA0 : 32'hA2, 7'h00, 21'h0, 1'b0};

        rst_n             = 1'b0;
        miss_valid        = 1'b0;
        miss_addr         = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_err   = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven fills.
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            w0 = wr_cnt;
            c0 = crit_cnt;
            t0 = tag_cnt;
            do_fill(vecs[i].addr, vecs[i].req_wait, vecs[i].gap, vecs[i].err_beat);
            chk("vec_writes", wr_cnt - w0, vecs[i].exp_writes);
            chk("vec_crit_cnt", crit_cnt - c0, vecs[i].exp_crit);
            if (vecs[i].exp_crit != 0) chk("vec_crit_data", last_crit_data, vecs[i].exp_crit_data);
            chk("vec_done_once", done_cnt - d0, 1);
            chk("vec_tag_once", tag_cnt - t0, 1);
            chk("vec_tag_idx", last_tag_idx, vecs[i].exp_idx);
            chk("vec_tag", last_tag, vecs[i].exp_tag);
            chk("vec_tag_valid", last_tag_valid, vecs[i].exp_valid);
            chk("vec_fill_err", last_fill_err, !vecs[i].exp_valid);
        end

        // Reset after beat 2: nothing commits, next fill is normal.
        d0 = done_cnt;
        t0 = tag_cnt;
        accept_miss(32'h0000_1234, 1'b0);
        grant(0);
        beat(0, 1'b0, 0);
        beat(1, 1'b0, 0);
        beat(2, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hA3;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk("rstmid_wr_en", wr_en, 0);
        chk("rstmid_tag_wr_en", tag_wr_en, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_no_tag", tag_cnt - t0, 0);
        chk("rstmid_idle", miss_ready, 1);
        do_fill(32'h0000_1234, 0, 0, 9);
        chk("rstmid_refill_done", done_cnt - d0, 1);

        // Back-to-back misses with stray beats across commit and idle.
        d0 = done_cnt;
        w0 = wr_cnt;
        accept_miss(32'h0000_1234, 1'b1);
        miss_addr = 32'h0000_2468;
        grant(0);
        for (int k = 0; k < 4; k++) beat(k, 1'b0, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        chk("b2b_ready_n2", miss_ready, 1);
        chk("b2b_stray_commit", wr_en, 0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        miss_valid        = 1'b0;
        chk("b2b_accept_n2", bus.mem_req_valid, 1);
        chk("b2b_busy", miss_ready, 0);
        chk("b2b_stray_idle", wr_en, 0);
        set_model(32'h0000_2468);
        chk("b2b_req_addr", bus.mem_req_addr, exp_req);
        grant(0);
        for (int k = 0; k < 4; k++) beat(k, 1'b0, 0);
        commit_check();
        chk("b2b_done_cnt", done_cnt - d0, 2);
        chk("b2b_wr_cnt", wr_cnt - w0, 8);
        chk("b2b_tag_idx", last_tag_idx, 7'h46);
        chk("b2b_tag", last_tag, 21'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
# icache_refill

Line-fill engine for the instruction cache data RAM. On a miss it issues one burst request to the memory bus, writes each returned beat into the 512-word data RAM through its write port (`wr_addr`/`wr_data`/`wr_en`), then writes the tag/valid entry and signals completion. It sits between the fetch miss logic and the memory interconnect, and is the only writer of the cache RAM.

## Interface
- `WIDTH`, 32, data beat width and RAM word width.
- `LINE_WORDS`, 4, words per cache line; a power of two; `LINE_WORDS` × line count = 512.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `miss_valid`  in  1  miss request.
- `miss_addr`  in  32  byte address of the missing instruction.
- `miss_ready`  out  1  engine idle; the miss is accepted when `miss_valid && miss_ready`.
- `mem_req_valid`  out  1  burst request.
- `mem_req_addr`  out  32  burst start byte address.
- `mem_req_ready`  in  1  request accepted when high with `mem_req_valid`.
- `mem_rsp_valid`  in  1  one response beat per cycle when high; there is no backpressure.
- `mem_rsp_data`  in  WIDTH  beat data.
- `mem_rsp_err`  in  1  bus error on this beat.
- `wr_addr`  out  9  RAM word address {index, word offset}.
- `wr_data`  out  WIDTH  RAM write data.
- `wr_en`  out  1  RAM write strobe.
- `tag_wr_en`  out  1  tag RAM write strobe.
- `tag_wr_index`  out  9-log2(LINE_WORDS)  line index.
- `tag_wr_tag`  out  32-2-9  tag, which is `miss_addr[31:11]`.
- `tag_wr_valid`  out  1  valid bit written with the tag.
- `crit_valid`  out  1  pulse when the missing word is written.
- `crit_data`  out  WIDTH  the missing word, for early restart.
- `fill_done`  out  1  one-cycle completion pulse.
- `fill_err`  out  1  qualifies `fill_done`; high means the fill failed.

## Operation
- **Address split.** Byte offset is `[1:0]`. Word offset is `[1+log2(LINE_WORDS):2]`. Index is the bits above the word offset, up to bit 10. Tag is `[31:11]`.
- **IDLE.** `miss_ready`=1. On accept, latch `miss_addr`, clear the beat counter and the error flag, then go to REQ.
- **REQ.** Hold `mem_req_valid`=1 and keep `mem_req_addr` stable until `mem_req_ready`, then go to FILL.
- **FILL.**
  - Each `mem_rsp_valid` beat increments the beat counter, which wraps modulo `LINE_WORDS`.
  - Beat word offset = (start offset + beat count) mod `LINE_WORDS`.
  - A beat writes the RAM only while the error flag is clear and the beat's `mem_rsp_err` is low.
  - `mem_rsp_err` sets the sticky error flag; the remaining beats are still consumed but not written.
  - After the `LINE_WORDS`-th beat, go to COMMIT.
- **COMMIT.** One cycle. `tag_wr_en`=1 and `tag_wr_valid`=!error. An errored fill therefore invalidates the line. `fill_done`=1 and `fill_err`=error. Return to IDLE.
- **`crit_valid`.** Pulses with the write of the beat whose offset equals the miss word offset. It is suppressed if that beat or an earlier beat errored.
- **Stray beats.** `mem_rsp_valid` outside FILL is ignored.
- **Reset.** Asserting `rst_n` low at any point, including mid-fill, forces IDLE, drops the error flag, and issues no tag write. RAM contents are left as they are; the tag stays invalid because no commit occurs.

## Timing
- All outputs are registered except `miss_ready`, which is decoded from state.
- Reset values: every output is 0 except `miss_ready`=1.
- **Request.** A miss accepted in cycle 0 gives `mem_req_valid`=1 from cycle 1.
- **Beats.** A beat in cycle N gives `wr_en`/`wr_addr`/`wr_data` in cycle N+1. `crit_valid`/`crit_data` are in N+1 as well.
- **Completion.** If the last beat arrives in cycle N:
  - the last `wr_en`, `tag_wr_en` and `fill_done` all fall in N+1;
  - `miss_ready`=1 from N+2;
  - a miss may be accepted in N+2.
- **Minimum fill.** The minimum fill is 1 (accept) + 1 (REQ) + `LINE_WORDS` (beats) + 1 (COMMIT) cycles.
- **Gaps.** Back-to-back beats and gaps between beats are both legal.

## Configuration
- **`ICACHE_REFILL_CWF_EN` defined: critical word first.**
  - `mem_req_addr` = word-aligned `miss_addr`.
  - The memory returns beats wrapping within the line.
  - The start offset is the miss word offset, so `crit_valid` accompanies the first write.
- **Undefined: in-order fill.**
  - `mem_req_addr` = line-aligned `miss_addr`.
  - The start offset is 0, and `crit_valid` accompanies the write of beat (miss word offset).

## Test plan
- **Clean fill.**
  - Stimulus: miss at 0x0000_1234, `mem_req_ready` immediate, beats 0xA0..0xA3 back-to-back.
  - Writes: `wr_addr` 0x08C..0x08F, in the order defined by the macro setting.
  - Commit: `tag_wr_index`=0x23, `tag_wr_tag`=0x2, `tag_wr_valid`=1, `fill_done`=1, `fill_err`=0.
- **Critical word.** Miss word offset 1.
  - Without the macro: `crit_valid` on the second write with data 0xA1.
  - With the macro: `mem_req_addr`=0x0000_1234 and `crit_valid` on the first write.
- **Error.**
  - Stimulus: `mem_rsp_err` on beat 1.
  - Required: only beat 0 is written; all 4 beats are consumed.
  - Commit: `tag_wr_valid`=0, `fill_err`=1; `crit_valid` is absent if the critical beat is ≥ 1.
- **Backpressure.** Hold `mem_req_ready` low for 5 cycles, then insert 2-cycle gaps between beats. Required: the request stays stable, each write is exactly one cycle after its beat, and `fill_done` occurs once.
- **Reset mid-fill.** Assert `rst_n` low after beat 2. Required: all outputs return to reset values immediately, with no `tag_wr_en` and no `fill_done`. The next miss fills normally.
- **Back-to-back.** Hold `miss_valid` high for two misses. Required: the second is accepted exactly 2 cycles after the first fill's last beat, and stray beats in IDLE produce no `wr_en`.
